// File: rtl/ha1588_pkg.sv
// Shared definitions for the ha1588 PTP core: register map, edge modes and
// the timestamp FIFO entry layout.
package ha1588_pkg;

  localparam int TS_W  = 80;
  localparam int SEQ_W = 16;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_EDGE   = 8'h04;
  localparam logic [7:0] ADDR_SEL    = 8'h08;
  localparam logic [7:0] ADDR_STAT   = 8'h0C;
  localparam logic [7:0] ADDR_TS_NS  = 8'h10;
  localparam logic [7:0] ADDR_TS_SLO = 8'h14;
  localparam logic [7:0] ADDR_TS_SHI = 8'h18;

  typedef enum logic [1:0] {
    EDGE_RISE  = 2'b00,
    EDGE_FALL  = 2'b01,
    EDGE_BOTH  = 2'b10,
    EDGE_RISE2 = 2'b11
  } edge_mode_e;

  // ts = {sec[47:0], ns[31:0]}
  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  function automatic logic edge_hit(input logic [1:0] mode, input logic cur,
                                    input logic prev);
    case (edge_mode_e'(mode))
      EDGE_FALL: return ~cur & prev;
      EDGE_BOTH: return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Single-clock synchronous FIFO with level/empty/full and a flush that
// overrides any push or pop in the same cycle.
module ts_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/ptp_ts_capture.sv
// Multi-channel event timestamp capture: per-channel edge detect, sequence
// numbering, FIFO storage and register-bus readout.
module ptp_ts_capture
  import ha1588_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_in,
  input  logic              rd_in,
  input  logic [7:0]        addr_in,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic [TS_W-1:0]   rtc_time_in,
  input  logic [NUM_CH-1:0] evt_in,
  output logic              evt_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0]   en_q, en_d, evt_q;
  logic [2*NUM_CH-1:0] edge_q, edge_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [SEQ_W-1:0]    seq_q [NUM_CH];
  logic [7:0]          ovf_q [NUM_CH];

  logic [NUM_CH-1:0]   hit, pop, empty, full;
  logic [LW-1:0]       level [NUM_CH];
  entry_t              head  [NUM_CH];
  logic                flush, wr_stat;

  entry_t              head_sel;
  logic [LW-1:0]       level_sel;
  logic                empty_sel, full_sel, head_ok;
  logic [7:0]          ovf_sel;
  logic                unused_bits;

  assign flush       = wr_in & (addr_in == ADDR_CTRL) & data_in[31];
  assign wr_stat     = wr_in & (addr_in == ADDR_STAT);
  assign evt_irq     = |(en_q & ~empty);
  assign data_out    = rdata_q;
  assign unused_bits = ^data_in;

  always_comb begin
    hit = '0;
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c] = en_q[c] & ~flush & edge_hit(edge_q[2*c +: 2], evt_in[c], evt_q[c]);
      pop[c] = rd_in & (addr_in == ADDR_TS_SHI) & (sel_q == 4'(c));
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ts_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n_i (rst),
      .push_i  (hit[c]),
      .pop_i   (pop[c]),
      .flush_i (flush),
      .din_i   ({rtc_time_in, seq_q[c]}),
      .dout_o  (head[c]),
      .level_o (level[c]),
      .empty_o (empty[c]),
      .full_o  (full[c])
    );
  end

  // Sequence ids advance on every detected edge, even when the entry is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        seq_q[c] <= '0;
        ovf_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hit[c]) seq_q[c] <= seq_q[c] + SEQ_W'(1);
        if (flush || (wr_stat && sel_q == 4'(c)))
          ovf_q[c] <= '0;
        else if (hit[c] && full[c] && !pop[c] && ovf_q[c] != 8'hFF)
          ovf_q[c] <= ovf_q[c] + 8'd1;
      end
    end
  end

  always_comb begin
    en_d   = en_q;
    edge_d = edge_q;
    sel_d  = sel_q;
    if (wr_in) begin
      case (addr_in)
        ADDR_CTRL: en_d   = data_in[NUM_CH-1:0];
        ADDR_EDGE: edge_d = data_in[2*NUM_CH-1:0];
        ADDR_SEL:  sel_d  = data_in[3:0];
        default: ;
      endcase
    end
  end

  // Out-of-range SEL values match no channel, so the whole window reads 0.
  always_comb begin
    head_sel  = '0;
    level_sel = '0;
    empty_sel = 1'b0;
    full_sel  = 1'b0;
    head_ok   = 1'b0;
    ovf_sel   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_q == 4'(c)) begin
        head_sel  = head[c];
        level_sel = level[c];
        empty_sel = empty[c];
        full_sel  = full[c];
        head_ok   = ~empty[c];
        ovf_sel   = ovf_q[c];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_in) begin
      rdata_d = '0;
      case (addr_in)
        ADDR_CTRL:   rdata_d = 32'(en_q);
        ADDR_EDGE:   rdata_d = 32'(edge_q);
        ADDR_SEL:    rdata_d = 32'(sel_q);
        ADDR_STAT:   rdata_d = {8'h00, ovf_sel, 5'h00, full_sel, empty_sel, 9'(level_sel)};
        ADDR_TS_NS:  if (head_ok) rdata_d = head_sel.ts[31:0];
        ADDR_TS_SLO: if (head_ok) rdata_d = head_sel.ts[63:32];
        ADDR_TS_SHI: if (head_ok) rdata_d = {head_sel.seq, head_sel.ts[79:64]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= '0;
      edge_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      evt_q   <= '0;
    end else begin
      en_q    <= en_d;
      edge_q  <= edge_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      evt_q   <= evt_in;
    end
  end

endmodule

// File: tb/tb_ptp_ts_capture.sv
// Directed and randomized bench for ptp_ts_capture against a queue-based
// transaction model of the capture unit.
module tb_ptp_ts_capture;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_in = 1'b0;
  logic           rd_in = 1'b0;
  logic [7:0]     addr_in = '0;
  logic [31:0]    data_in = '0;
  logic [31:0]    data_out;
  logic [79:0]    rtc_time_in = '0;
  logic [NCH-1:0] evt_in = '0;
  logic           evt_irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ptp_ts_capture #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_in       (wr_in),
    .rd_in       (rd_in),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .rtc_time_in (rtc_time_in),
    .evt_in      (evt_in),
    .evt_irq     (evt_irq)
  );

  // Model state: entry = {sec[47:0], ns[31:0], seq[15:0]}
  logic [95:0]    mq [NCH][$];
  int unsigned    mseq [NCH];
  int unsigned    movf [NCH];
  logic [NCH-1:0] men, mprev, evt_cur;
  logic [7:0]     medge;
  logic [3:0]     msel;
  logic [31:0]    m_rdata;
  bit             rand_rtc;
  logic [7:0]     rd_addrs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                                    8'h14, 8'h18, 8'h18, 8'h1C, 8'h40};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      mseq[c] = 0;
      movf[c] = 0;
    end
    men = '0; medge = '0; msel = '0; mprev = '0; m_rdata = '0;
  endtask

  function automatic bit m_edge(input logic [1:0] m, input bit cur, input bit prev);
    case (m)
      2'b01:   return prev && !cur;
      2'b10:   return cur != prev;
      default: return cur && !prev;
    endcase
  endfunction

  function automatic bit m_irq();
    for (int c = 0; c < NCH; c++)
      if (men[c] && mq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int s = int'(msel);
    logic [95:0] e;
    case (a)
      8'h00: return 32'(men);
      8'h04: return 32'(medge);
      8'h08: return 32'(msel);
      8'h0C: if (s < NCH)
               return (32'(movf[s]) << 16) | (32'(mq[s].size() == DEPTH) << 10) |
                      (32'(mq[s].size() == 0) << 9) | 32'(mq[s].size());
      8'h10, 8'h14, 8'h18: if (s < NCH && mq[s].size() > 0) begin
               e = mq[s][0];
               if (a == 8'h10) return e[47:16];
               if (a == 8'h14) return e[79:48];
               return {e[15:0], e[95:80]};
             end
      default: ;
    endcase
    return 32'h0;
  endfunction

  // One clock: apply inputs, advance the model, then check outputs after the edge.
  task automatic cycle(input logic [NCH-1:0] ev, input bit wr, input bit rd,
                       input logic [7:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    bit fl;
    int s;
    evt_in = ev; wr_in = wr; rd_in = rd; addr_in = a; data_in = d;
    if (rand_rtc) rtc_time_in = {16'($urandom), $urandom, $urandom};
    exp_rd = model_read(a);
    fl = wr && a == 8'h00 && d[31];
    s = int'(msel);
    if (rd && a == 8'h18 && s < NCH && mq[s].size() > 0) void'(mq[s].pop_front());
    for (int c = 0; c < NCH; c++) begin
      if (men[c] && !fl && m_edge(medge[2*c +: 2], ev[c], mprev[c])) begin
        if (mq[c].size() < DEPTH) mq[c].push_back({rtc_time_in, 16'(mseq[c])});
        else if (movf[c] < 255) movf[c]++;
        mseq[c] = (mseq[c] + 1) % 65536;
      end
    end
    mprev = ev;
    if (wr) begin
      case (a)
        8'h00: begin
          men = d[NCH-1:0];
          if (d[31]) for (int c = 0; c < NCH; c++) begin mq[c].delete(); movf[c] = 0; end
        end
        8'h04: medge = d[7:0];
        8'h08: msel = d[3:0];
        8'h0C: if (s < NCH) movf[s] = 0;
        default: ;
      endcase
    end
    if (rd) m_rdata = exp_rd;
    @(posedge clk);
    #1;
    wr_in = 1'b0; rd_in = 1'b0;
    chk("data_out", data_out, m_rdata);
    chk("evt_irq", 32'(evt_irq), 32'(m_irq()));
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    cycle(evt_cur, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input logic [7:0] a);
    cycle(evt_cur, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic step(input logic [NCH-1:0] ev);
    evt_cur = ev;
    cycle(ev, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  initial begin
    logic [79:0]    ts3;
    logic [NCH-1:0] ev;
    logic [7:0]     a;
    logic [31:0]    d;
    int             r;
    evt_cur = '0;
    rand_rtc = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_irq", 32'(evt_irq), 32'h0);
    rst = 1'b1;
    rd_reg(8'h00);
    rd_reg(8'h04);

    // Single rising capture on ch0 with a fixed RTC value
    rand_rtc = 1'b0;
    rtc_time_in = {48'h1_0000_0005, 32'h3B9AC9FF};
    wr_reg(8'h00, 32'h1);
    step(4'b0001);
    rd_reg(8'h0C); chk("t1_level", data_out, 32'h0000_0001);
    rd_reg(8'h10); chk("t1_ns", data_out, 32'h3B9AC9FF);
    rd_reg(8'h14); chk("t1_sec_lo", data_out, 32'h0000_0005);
    rd_reg(8'h18); chk("t1_sec_hi", data_out, 32'h0000_0001);
    rd_reg(8'h0C); chk("t1_empty", data_out, 32'h0000_0200);
    rand_rtc = 1'b1;

    // ch1 both-edge overflow
    wr_reg(8'h04, 32'h8);
    wr_reg(8'h00, 32'h2);
    for (int i = 0; i < 6; i++) step(evt_cur ^ 4'b0010);
    wr_reg(8'h08, 32'h1);
    rd_reg(8'h0C); chk("t2_stat", data_out, 32'h0002_0404);
    for (int i = 0; i < 4; i++) begin
      rd_reg(8'h18); chk("t2_seq", 32'(data_out[31:16]), 32'(i));
    end
    step(evt_cur ^ 4'b0010);
    rd_reg(8'h18); chk("t2_seq6", 32'(data_out[31:16]), 32'd6);
    wr_reg(8'h0C, 32'h0);
    rd_reg(8'h0C); chk("t2_ovf_clr", data_out, 32'h0000_0200);

    // ch2 falling + ch3 rising in the same cycle
    wr_reg(8'h04, 32'h10);
    wr_reg(8'h00, 32'hC);
    step(evt_cur | 4'b0100);
    step((evt_cur & 4'b1011) | 4'b1000);
    ts3 = rtc_time_in;
    wr_reg(8'h08, 32'h3);
    rd_reg(8'h0C); chk("t3_lvl3", data_out, 32'h0000_0001);
    rd_reg(8'h10); chk("t3_ns3", data_out, ts3[31:0]);
    rd_reg(8'h18); chk("t3_hi3", data_out, {16'h0, ts3[79:64]});
    chk("t3_irq_on", 32'(evt_irq), 32'h1);
    wr_reg(8'h08, 32'h2);
    rd_reg(8'h0C); chk("t3_lvl2", data_out, 32'h0000_0001);
    rd_reg(8'h14); chk("t3_slo2", data_out, ts3[63:32]);
    rd_reg(8'h18); chk("t3_hi2", data_out, {16'h0, ts3[79:64]});
    chk("t3_irq_off", 32'(evt_irq), 32'h0);

    // ch0 full: pop and push in the same cycle
    wr_reg(8'h00, 32'h1);
    wr_reg(8'h08, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(evt_cur & 4'b1110);
      step(evt_cur | 4'b0001);
    end
    rd_reg(8'h0C); chk("t4_full", data_out, 32'h0000_0404);
    step(evt_cur & 4'b1110);
    evt_cur = evt_cur | 4'b0001;
    cycle(evt_cur, 1'b0, 1'b1, 8'h18, 32'h0);
    chk("t4_pop_seq", 32'(data_out[31:16]), 32'd1);
    rd_reg(8'h0C); chk("t4_still_full", data_out, 32'h0000_0404);

    // Overflow then flush; sequence ids continue
    step(evt_cur & 4'b1110);
    step(evt_cur | 4'b0001);
    rd_reg(8'h0C); chk("t5_ovf", data_out, 32'h0001_0404);
    wr_reg(8'h00, 32'h8000_0001);
    chk("t5_irq", 32'(evt_irq), 32'h0);
    rd_reg(8'h0C); chk("t5_flushed", data_out, 32'h0000_0200);
    rd_reg(8'h00); chk("t5_ctrl", data_out, 32'h0000_0001);
    step(evt_cur & 4'b1110);
    step(evt_cur | 4'b0001);
    rd_reg(8'h18); chk("t5_seq", 32'(data_out[31:16]), 32'd7);

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) begin
      step(evt_cur & 4'b1110);
      step(evt_cur | 4'b0001);
    end
    rd_reg(8'h0C); chk("t6_lvl3", data_out, 32'h0000_0003);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_data", data_out, 32'h0);
    chk("t6_rst_irq", 32'(evt_irq), 32'h0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    rd_reg(8'h0C); chk("t6_level", data_out, 32'h0000_0200);
    rd_reg(8'h00); chk("t6_ctrl", data_out, 32'h0);
    step(evt_cur & 4'b1110);
    step(evt_cur | 4'b0001);
    rd_reg(8'h0C); chk("t6_ignored", data_out, 32'h0000_0200);
    wr_reg(8'h00, 32'h1);
    step(evt_cur & 4'b1110);
    step(evt_cur | 4'b0001);
    rd_reg(8'h18); chk("t6_seq0", 32'(data_out[31:16]), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      ev = ($urandom_range(0, 2) == 0) ? (evt_cur ^ NCH'($urandom)) : evt_cur;
      if (r < 4) begin
        step(evt_cur ^ NCH'($urandom));
      end else if (r < 7) begin
        evt_cur = ev;
        cycle(ev, 1'b0, 1'b1, rd_addrs[$urandom_range(0, 9)], 32'h0);
      end else begin
        case ($urandom_range(0, 4))
          0: begin a = 8'h00; d = {($urandom_range(0, 7) == 0), 27'h0, 4'($urandom)}; end
          1: begin a = 8'h04; d = $urandom; end
          2: begin a = 8'h08; d = 32'($urandom_range(0, 6)); end
          3: begin a = 8'h0C; d = $urandom; end
          default: begin a = 8'h1C; d = $urandom; end
        endcase
        if (a == 8'h00 && d[31]) ev = evt_cur;
        evt_cur = ev;
        cycle(ev, 1'b1, 1'b0, a, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
